// File: rtl/sfir_pkg.sv
// Shared definitions for the symmetric FIR output stages: default widths and
// the round-half-up scaling helper.
package sfir_pkg;

    localparam int PRODUCT_WIDTH = 32;
    localparam int OUT_WIDTH     = 16;

    // Working width for round_shift; wide enough for any product width up to 62 bits.
    localparam int ROUND_WIDTH   = 64;

    // Adds one half LSB of the target scale, then shifts arithmetically.
    // Round-half-up: +0.5 goes to 1 and -0.5 goes to 0.
    function automatic logic signed [ROUND_WIDTH-1:0] round_shift(
        input logic signed [ROUND_WIDTH-1:0] value,
        input int unsigned                   shift
    );
        logic signed [ROUND_WIDTH-1:0] half;
        logic signed [ROUND_WIDTH-1:0] sum;
        half = ROUND_WIDTH'(1) << (shift - 1);
        sum  = value + half;
        return sum >>> shift;
    endfunction

endpackage

// File: rtl/sfir_out_fifo.sv
// Synchronous output FIFO. Pointers carry one extra wrap bit so full and empty
// come straight from the pointers. A push into a full FIFO is accepted only if
// a pop frees a slot in the same cycle. The head is read out of the storage
// flops and forced to zero while the FIFO is empty.
module sfir_out_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  full_o,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    // Status flags, accepted handshakes and next pointer values.
    always_comb begin
        // NOTE: every signal written here gets a value on every path; a missing default would infer a latch.
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        data_o   = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Sample storage, written at the slot the write pointer addresses.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is deliberately not reset; the pointers alone decide which entries are live.
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/sfir_decim_output.sv
// Output conditioning after the symmetric FIR: decimate by DECIM, round and
// shift by SHIFT, limit to OUT_WIDTH, buffer in a FIFO with a valid/ready output.
// Pipeline: input/keep register, rounding stage, range-limit stage, FIFO write.
// Build option SFIR_DECIM_SAT_EN: saturate and flag clipping on sat_o;
// otherwise the result wraps to the low OUT_WIDTH bits and sat_o is 0.
module sfir_decim_output #(
    parameter int IN_WIDTH   = sfir_pkg::PRODUCT_WIDTH,
    parameter int OUT_WIDTH  = sfir_pkg::OUT_WIDTH,
    parameter int SHIFT      = 15,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IN_WIDTH-1:0]  data_i,
    input  logic                 valid_i,
    input  logic                 phase_clr_i,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 sat_o,
    output logic                 drop_o
);

    import sfir_pkg::*;

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

`ifdef SFIR_DECIM_SAT_EN
    // Full rounded value is kept so the limiter can see every overflow bit.
    localparam int S1_W = IN_WIDTH + 1;
`else
    // Wrapping only ever needs the low OUT_WIDTH bits of the rounded value.
    localparam int S1_W = OUT_WIDTH;
`endif

    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_eff;
    logic                 in_valid_q, in_valid_d;
    logic [IN_WIDTH-1:0]  in_data_q, in_data_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [S1_W-1:0]      s1_data_q, s1_data_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [OUT_WIDTH-1:0] s2_data_q, s2_data_d;
    logic                 drop_q, drop_d;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    // Decimation phase: phase_clr_i forces this cycle's phase to zero.
    always_comb begin
        cnt_eff    = phase_clr_i ? '0 : cnt_q;
        cnt_d      = cnt_q;
        if (valid_i) begin
            cnt_d = (cnt_eff == CNT_LAST) ? '0 : cnt_eff + 1'b1;
        end
        in_valid_d = valid_i && (cnt_eff == '0);
        in_data_d  = data_i;
    end

    // Stage 1: add half an output LSB and shift arithmetically.
    always_comb begin
        s1_valid_d = in_valid_q;
        s1_data_d  = S1_W'(round_shift(ROUND_WIDTH'($signed(in_data_q)), SHIFT));
    end

`ifdef SFIR_DECIM_SAT_EN
    logic                        sat_q, sat_d;
    logic [S1_W-OUT_WIDTH:0]     s1_hi;
    logic                        s1_clip;

    // Stage 2: saturate when the bits above the output sign disagree with it.
    always_comb begin
        s2_valid_d = s1_valid_q;
        s1_hi      = s1_data_q[S1_W-1:OUT_WIDTH-1];
        s1_clip    = !((&s1_hi) || !(|s1_hi));
        s2_data_d  = s1_clip ? {s1_data_q[S1_W-1], {(OUT_WIDTH-1){~s1_data_q[S1_W-1]}}}
                             : s1_data_q[OUT_WIDTH-1:0];
        sat_d      = sat_q || (s1_valid_q && s1_clip);
    end

    // Sticky clip flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_o = sat_q;
`else
    // Stage 2: two's-complement wrap to the output width.
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_data_d  = s1_data_q;
    end

    assign sat_o = 1'b0;
`endif

    // Drop pulse: a stage-2 sample meets a full FIFO that is not draining.
    always_comb begin
        pop    = !fifo_empty && ready_i;
        drop_d = s2_valid_q && fifo_full && !pop;
    end

    // Counter, pipeline and drop registers; reset discards samples in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            in_valid_q <= 1'b0;
            in_data_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            drop_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            in_valid_q <= in_valid_d;
            in_data_q  <= in_data_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            drop_q     <= drop_d;
        end
    end

    sfir_out_fifo #(
        .DATA_WIDTH (OUT_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (s2_valid_q),
        .data_i  (s2_data_q),
        .full_o  (fifo_full),
        .pop_i   (pop),
        .data_o  (data_o),
        .empty_o (fifo_empty)
    );

    assign valid_o = !fifo_empty;
    assign drop_o  = drop_q;

endmodule

// File: tb/tb_sfir_decim_output.sv
// Directed bench for sfir_decim_output: one instance at DECIM=1 for rounding,
// range limit, latency, throughput, backpressure and reset; one at DECIM=4
// for decimation and phase clear. Expected values are hand-computed.
module tb_sfir_decim_output;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        phase_clr1 = 1'b0;
    logic        phase_clr4 = 1'b0;
    logic        ready1 = 1'b1;
    logic        ready4 = 1'b1;
    logic [15:0] data1, data4;
    logic        valid1, valid4;
    logic        sat1, sat4;
    logic        drop1, drop4;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int din;
        int exp_sat_data;
        int exp_wrap_data;
        bit clips;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    sfir_decim_output #(
        .IN_WIDTH (32), .OUT_WIDTH (16), .SHIFT (15), .DECIM (1), .FIFO_DEPTH (4)
    ) u_dut1 (
        .clk_i (clk), .rst_i (rst_i), .data_i (data_i), .valid_i (valid_i),
        .phase_clr_i (phase_clr1), .data_o (data1), .valid_o (valid1),
        .ready_i (ready1), .sat_o (sat1), .drop_o (drop1)
    );

    sfir_decim_output #(
        .IN_WIDTH (32), .OUT_WIDTH (16), .SHIFT (15), .DECIM (4), .FIFO_DEPTH (4)
    ) u_dut4 (
        .clk_i (clk), .rst_i (rst_i), .data_i (data_i), .valid_i (valid_i),
        .phase_clr_i (phase_clr4), .data_o (data4), .valid_o (valid4),
        .ready_i (ready4), .sat_o (sat4), .drop_o (drop4)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One sample into DUT1; returns cycles to valid_o, head data, sat, and valid_o one cycle later.
    task automatic send1(input int din, output int lat, output int dout,
                         output int sat, output int after);
        data_i  = din;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        lat = 1;
        while (valid1 !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        dout = int'($signed(data1));
        sat  = int'(sat1);
        @(negedge clk);
        after = int'(valid1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, dout, sat, after, exp_d, sat_model, n_drop, d0, d1, n_valid;
        int outs [$];
        int cycs [$];
        int dec_exp [5];

        vecs[0] = '{3276800,              100,    100,    1'b0};
        vecs[1] = '{16384,                1,      1,      1'b0};
        vecs[2] = '{-16384,               0,      0,      1'b0};
        vecs[3] = '{-16385,               -1,     -1,     1'b0};
        vecs[4] = '{-3293184,             -100,   -100,   1'b0};
        vecs[5] = '{1073709056,           32767,  32767,  1'b0};
        vecs[6] = '{1073741824,           32767,  -32768, 1'b1};
        vecs[7] = '{2147483647,           32767,  0,      1'b1};
        vecs[8] = '{int'(32'h8000_0000),  -32768, 0,      1'b1};
        dec_exp = '{0, 4, 6, 10, 14};

        // Reset state
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        check("reset valid_o", int'(valid1), 0);
        check("reset data_o", int'(data1), 0);
        check("reset sat_o", int'(sat1), 0);
        check("reset drop_o", int'(drop1), 0);
        check("reset valid_o dec4", int'(valid4), 0);
        rst_i = 1'b0;

        // Decimation by 4 with a phase clear on input 6
        for (int c = 0; c < 22; c++) begin
            if (c < 16) begin
                data_i     = c * 32768;
                valid_i    = 1'b1;
                phase_clr4 = (c == 6);
            end else begin
                valid_i    = 1'b0;
                phase_clr4 = 1'b0;
            end
            @(negedge clk);
            if (valid4) outs.push_back(int'($signed(data4)));
        end
        check("decim output count", outs.size(), 5);
        for (int i = 0; i < outs.size() && i < 5; i++)
            check($sformatf("decim out %0d", i), outs[i], dec_exp[i]);
        outs.delete();
        repeat (4) @(negedge clk);

        // Rounding and range-limit vectors, one sample at a time
        sat_model = 0;
        for (int i = 0; i < 9; i++) begin
            send1(vecs[i].din, lat, dout, sat, after);
`ifdef SFIR_DECIM_SAT_EN
            exp_d     = vecs[i].exp_sat_data;
            sat_model = sat_model | int'(vecs[i].clips);
`else
            exp_d     = vecs[i].exp_wrap_data;
`endif
            check($sformatf("vec%0d latency", i), lat, 4);
            check($sformatf("vec%0d data_o", i), dout, exp_d);
            check($sformatf("vec%0d sat_o", i), sat, sat_model);
            check($sformatf("vec%0d valid_o after pop", i), after, 0);
        end

        // Throughput: five back-to-back samples, ready held high
        ready1 = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c < 5) begin
                data_i  = (c + 1) * 32768;
                valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk);
            if (valid1) begin
                outs.push_back(int'($signed(data1)));
                cycs.push_back(c);
            end
        end
        check("burst output count", outs.size(), 5);
        for (int i = 0; i < outs.size(); i++)
            check($sformatf("burst out %0d", i), outs[i], i + 1);
        if (cycs.size() > 0) begin
            check("burst first valid cycle", cycs[0], 3);
            check("burst span without bubbles", cycs[cycs.size()-1] - cycs[0], 4);
        end
        outs.delete();
        cycs.delete();

        // Backpressure: six samples into a four-entry FIFO with ready low
        ready1 = 1'b0;
        n_drop = 0;
        d0 = -1;
        d1 = -1;
        for (int c = 0; c < 14; c++) begin
            if (c < 6) begin
                data_i  = (11 + c) * 32768;
                valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk);
            if (drop1) begin
                if (n_drop == 0) d0 = c;
                else if (n_drop == 1) d1 = c;
                n_drop++;
            end
        end
        check("drop pulse count", n_drop, 2);
        check("drop pulses consecutive", d1 - d0, 1);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall valid_o %0d", c), int'(valid1), 1);
            check($sformatf("stall data_o %0d", c), int'($signed(data1)), 11);
            @(negedge clk);
        end
        ready1 = 1'b1;
        n_drop = 0;
        for (int c = 0; c < 8; c++) begin
            if (valid1) outs.push_back(int'($signed(data1)));
            if (drop1) n_drop++;
            @(negedge clk);
        end
        check("drain output count", outs.size(), 4);
        for (int i = 0; i < outs.size(); i++)
            check($sformatf("drain out %0d", i), outs[i], 11 + i);
        check("drain drop count", n_drop, 0);
        outs.delete();

        // Reset mid-stream with a full FIFO and samples still in the pipeline
        ready1 = 1'b0;
        for (int c = 0; c < 7; c++) begin
            data_i  = (21 + c) * 32768;
            valid_i = 1'b1;
            @(negedge clk);
        end
        valid_i = 1'b0;
        check("pre-reset valid_o", int'(valid1), 1);
        rst_i = 1'b1;
        @(negedge clk);
        check("mid reset valid_o", int'(valid1), 0);
        check("mid reset data_o", int'(data1), 0);
        check("mid reset drop_o", int'(drop1), 0);
        rst_i  = 1'b0;
        ready1 = 1'b1;
        n_valid = 0;
        n_drop  = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (valid1) n_valid++;
            if (drop1) n_drop++;
        end
        check("stale samples after reset", n_valid, 0);
        check("drops after reset", n_drop, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sfir_decim_output.md
# sfir_decim_output

Output conditioning stage placed directly downstream of the systolic symmetric FIR. It takes the full-precision signed product stream (PRODUCT_WIDTH bits, one sample per clock), keeps one sample in DECIM, rounds and scales it to OUT_WIDTH, saturates it, and buffers the result in a small FIFO. The FIFO presents a valid/ready stream to the consumer and reports dropped samples when backpressure overflows it.

## Interface
- IN_WIDTH, 32: signed input width; equals the FIR PRODUCT_WIDTH.
- OUT_WIDTH, 16: signed output width.
- SHIFT, 15: right-shift applied after rounding; range 1..IN_WIDTH-1.
- DECIM, 4: decimation factor; range 1..256.
- FIFO_DEPTH, 4: output buffer depth; power of two, 2 or more.

Ports (name, direction, width, meaning):
- clk_i  in  1  clock.
- rst_i  in  1  reset; **one clock; reset is synchronous and active-high.**
- data_i  in  IN_WIDTH  signed FIR product.
- valid_i  in  1  data_i is valid this cycle.
- phase_clr_i  in  1  restarts the decimation phase.
- data_o  out  OUT_WIDTH  signed scaled sample.
- valid_o  out  1  data_o is valid.
- ready_i  in  1  consumer accepts data_o.
- sat_o  out  1  sticky flag: at least one sample has clipped.
- drop_o  out  1  one-cycle pulse: a sample was lost because the FIFO was full.

## Operation
- Decimation counter cnt runs 0..DECIM-1.
  - It advances only on valid_i and wraps from DECIM-1 to 0.
  - A sample is kept when valid_i=1 and the effective cnt is 0.
  - phase_clr_i=1 forces the effective cnt to 0 for that cycle. If valid_i is also 1, that sample is kept and cnt becomes 1 (or stays 0 when DECIM=1).
  - DECIM=1 keeps every valid sample.
- Stage 1 (rounding): computes r = (data_i + 2^(SHIFT-1)) >>> SHIFT in IN_WIDTH+1 bits with an arithmetic shift. This is round-half-up: +0.5 rounds to 1, -0.5 rounds to 0.
- Stage 2 (range limit): r is limited to the OUT_WIDTH signed range.
  - Clipping, when enabled, sets sat_o.
  - The stage-2 output is the FIFO write.
- FIFO write (push) rules:
  - When not full, the sample is written.
  - When full and not popping in the same cycle, the sample is discarded and drop_o pulses in the following cycle.
  - When full and popping in the same cycle, the write succeeds and there is no drop.
- FIFO read (pop): pop = valid_o & ready_i. data_o is the FIFO head, and valid_o = not empty.
- FIFO wrap-around: read and write pointers are log2(FIFO_DEPTH) bits plus one wrap bit; full and empty are derived from the pointers.
- When ready_i is held low, the FIFO fills and drops after FIFO_DEPTH accepted samples. data_o and valid_o stay stable while valid_o=1 and ready_i=0.
- Reset has priority over every other input:
  - cnt, both pipeline stages, the FIFO pointers, sat_o and drop_o all clear.
  - Samples in flight when reset is applied are lost.
  - A reset asserted mid-stream clears valid_o in the cycle after the reset edge.

## Timing
- Reset values: valid_o=0, data_o=0, sat_o=0, drop_o=0.
- Latency: a kept sample presented at edge N produces valid_o=1 in the cycle after edge N+3. The path is stage 1 at N+1, stage 2 at N+2, FIFO write at N+3, and a registered head visible after N+3.
- Throughput: one sample per clock at DECIM=1 with ready_i held high, with no bubbles.
- drop_o asserts for exactly one cycle per lost sample; consecutive losses give consecutive pulses.

## Configuration
- SFIR_DECIM_SAT_EN defined: stage 2 saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and sets sat_o on clipping.
- SFIR_DECIM_SAT_EN undefined: stage 2 keeps the low OUT_WIDTH bits (two's-complement wrap), and sat_o is tied to 0.

## Structure
- Shared package sfir_pkg holds:
  - the default width constants PRODUCT_WIDTH and OUT_WIDTH;
  - a round_shift function that performs the add-half and arithmetic shift, shared with future FIR output stages.
- Sub-module sfir_out_fifo: synchronous FIFO with parameters DATA_WIDTH and DEPTH, sync active-high rst_i, push/full and pop/empty, and a registered head.
- The top level contains the decimation counter, the two pipeline stages and the drop logic.

## Test plan
All scenarios use SHIFT=15 and OUT_WIDTH=16.
- Reset, then valid_i=1 with data_i=3276800 (100·2^15), DECIM=1, ready_i=1 -> data_o=100 with valid_o rising 4 cycles after the input edge.
- Rounding: data_i=16384 -> data_o=1; data_i=-16384 -> data_o=0; data_i=-16385 -> data_o=-1.
- Range limit: data_i=0x7FFFFFFF.
  - With SFIR_DECIM_SAT_EN: data_o=32767 and sat_o=1, and sat_o stays 1.
  - Without SFIR_DECIM_SAT_EN: data_o=0 and sat_o=0.
- Decimation: DECIM=4 with the ramp 0,1,2,…·2^15 -> outputs 0,4,8,…. A phase_clr_i pulse aligned with input 6 -> following outputs 6,10,….
- Backpressure: ready_i=0, DECIM=1, FIFO_DEPTH=4, 6 samples -> 4 stored and 2 drop_o pulses. Raising ready_i then yields the first 4 samples in order.
- Reset mid-stream with a full FIFO -> valid_o=0 the next cycle, and no stale samples appear after reset is released.
